// File: rtl/mux_scan_pkg.sv
// Shared types and mode encodings for the scanning multiplexer and its users.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_SCAN   = 2'd1;
    localparam logic [1:0] MODE_BURST  = 2'd2;

endpackage

// File: rtl/mux_scan_seq_mux_n1.sv
// Combinational N_CH:1 selector of W-bit channels; flags selects that name no channel.
module mux_n1 #(
    parameter int N_CH  = 3,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] in_data,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic              in_range
);

    logic [W-1:0] chan [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // Out-of-range selects yield zero rather than an undefined array read.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = chan[k];
            end
        end
    end

    assign in_range = ({1'b0, sel} < (SEL_W + 1)'(N_CH));

endmodule

// File: rtl/mux_scan_seq.sv
// Registered N-channel multiplexer with manual, round-robin scan and counted burst modes,
// presenting captures on a valid/ready stream that holds until accepted.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int  N_CH  = 3,
    parameter int  W     = 8,
    parameter int  CNT_W = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              start,
    input  logic              stop,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              sel_err,
    output logic [CNT_W-1:0]  beat_cnt
);

    state_t             state_reg, state_next;
    logic [1:0]         mode_reg, mode_next;
    logic [CNT_W-1:0]   len_reg, len_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;
    logic [W-1:0]       data_reg, data_next;
    logic [SEL_W-1:0]   ch_reg, ch_next;
    logic               valid_reg, valid_next;
    logic               err_reg, err_next;

    logic               is_manual;
    logic               is_burst;
    logic               zero_burst;
    logic               cap_ok;
    logic               capture;
    logic [SEL_W-1:0]   ch_sel;
    logic [SEL_W-1:0]   ptr_adv;
    logic [CNT_W-1:0]   cnt_inc;
    logic [W-1:0]       mux_out;
    logic               mux_ok;

    assign is_manual  = (mode_reg == MODE_MANUAL);
    assign is_burst   = (mode_reg == MODE_BURST);
    assign zero_burst = is_burst && (len_reg == '0);
    assign ch_sel     = is_manual ? sel_in : ptr_reg;
    assign ptr_adv    = (ptr_reg == SEL_W'(N_CH - 1)) ? '0 : ptr_reg + 1'b1;
    assign cnt_inc    = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
    assign cap_ok     = !valid_reg || out_ready;
    assign capture    = (state_reg == RUN) && cap_ok && mux_ok && !zero_burst;

    mux_n1 #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_mux (
        .in_data  (in_data),
        .sel      (ch_sel),
        .out_data (mux_out),
        .in_range (mux_ok)
    );

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        data_next  = data_reg;
        ch_next    = ch_reg;
        valid_next = valid_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                    mode_next  = mode;
                    len_next   = burst_len;
                    ptr_next   = '0;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end
            end
            RUN: begin
                if (capture) begin
                    data_next  = mux_out;
                    ch_next    = ch_sel;
                    valid_next = 1'b1;
                    cnt_next   = cnt_inc;
                    if (!is_manual) begin
                        ptr_next = ptr_adv;
                    end
                end else if (valid_reg && out_ready) begin
                    valid_next = 1'b0;
                end
                if (cap_ok && is_manual && !mux_ok) begin
                    err_next = 1'b1;
                end
                // A capture in the stop cycle still lands; the beat then drains normally.
                if (stop || zero_burst || (capture && is_burst && cnt_inc == len_reg)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!valid_reg) begin
                    state_next = DONE;
                end else if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_MANUAL;
            len_reg   <= '0;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            data_reg  <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            data_reg  <= data_next;
            ch_reg    <= ch_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    assign out_data  = data_reg;
    assign out_ch    = ch_reg;
    assign out_valid = valid_reg;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign sel_err   = err_reg;
    assign beat_cnt  = cnt_reg;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed vector bench for mux_scan_seq with N_CH=3, W=8 and channels A1/B2/C3.
module tb_mux_scan_seq;

    localparam int N_CH  = 3;
    localparam int W     = 8;
    localparam int CNT_W = 8;
    localparam int SEL_W = $clog2(N_CH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N_CH*W-1:0] in_data;
    logic [1:0]        mode;
    logic [SEL_W-1:0]  sel_in;
    logic [CNT_W-1:0]  burst_len;
    logic              start;
    logic              stop;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              sel_err;
    logic [CNT_W-1:0]  beat_cnt;

    int compared   = 0;
    int mismatched = 0;

    mux_scan_seq #(
        .N_CH  (N_CH),
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .mode      (mode),
        .sel_in    (sel_in),
        .burst_len (burst_len),
        .start     (start),
        .stop      (stop),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .sel_err   (sel_err),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic       rdy;
        logic [1:0] md;
        logic [1:0] sel;
        logic [7:0] len;
        logic       v;
        logic [1:0] ch;
        logic [7:0] d;
        logic       bsy;
        logic       dn;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic rdy,
                                input logic [1:0] md, input logic [1:0] sel, input logic [7:0] len,
                                input logic v, input logic [1:0] ch, input logic [7:0] d,
                                input logic bsy, input logic dn, input logic [7:0] cnt,
                                input logic err);
        vec_t r;
        r.st = st; r.sp = sp; r.rdy = rdy; r.md = md; r.sel = sel; r.len = len;
        r.v = v; r.ch = ch; r.d = d; r.bsy = bsy; r.dn = dn; r.cnt = cnt; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_data   = {8'hC3, 8'hB2, 8'hA1};
        mode      = 2'd0;
        sel_in    = '0;
        burst_len = '0;
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b1;

        // Burst of 5 at full throughput.
        tbl.push_back(mk(1,0,1, 2,0,5, 0,0,8'h00, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 2,0,5, 1,0,8'hA1, 1,0,1,0));
        tbl.push_back(mk(0,0,1, 2,0,5, 1,1,8'hB2, 1,0,2,0));
        tbl.push_back(mk(0,0,1, 2,0,5, 1,2,8'hC3, 1,0,3,0));
        tbl.push_back(mk(0,0,1, 2,0,5, 1,0,8'hA1, 1,0,4,0));
        tbl.push_back(mk(0,0,1, 2,0,5, 1,1,8'hB2, 1,0,5,0));
        tbl.push_back(mk(0,0,1, 2,0,5, 0,0,8'h00, 0,1,5,0));
        tbl.push_back(mk(0,0,1, 2,0,5, 0,0,8'h00, 0,0,5,0));
        // start together with stop is ignored.
        tbl.push_back(mk(1,1,1, 2,0,5, 0,0,8'h00, 0,0,5,0));
        // Burst of 4 with ready pattern 1,0,0 repeating.
        tbl.push_back(mk(1,0,1, 2,0,4, 0,0,8'h00, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 2,0,4, 1,0,8'hA1, 1,0,1,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,0,8'hA1, 1,0,1,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,0,8'hA1, 1,0,1,0));
        tbl.push_back(mk(0,0,1, 2,0,4, 1,1,8'hB2, 1,0,2,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,1,8'hB2, 1,0,2,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,1,8'hB2, 1,0,2,0));
        tbl.push_back(mk(0,0,1, 2,0,4, 1,2,8'hC3, 1,0,3,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,2,8'hC3, 1,0,3,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,2,8'hC3, 1,0,3,0));
        tbl.push_back(mk(0,0,1, 2,0,4, 1,0,8'hA1, 1,0,4,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,0,8'hA1, 1,0,4,0));
        tbl.push_back(mk(0,0,0, 2,0,4, 1,0,8'hA1, 1,0,4,0));
        tbl.push_back(mk(0,0,1, 2,0,4, 0,0,8'h00, 0,1,4,0));
        tbl.push_back(mk(0,0,1, 2,0,4, 0,0,8'h00, 0,0,4,0));
        // Manual select, then an out-of-range select, then stop.
        tbl.push_back(mk(1,0,1, 0,2,0, 0,0,8'h00, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 0,2,0, 1,2,8'hC3, 1,0,1,0));
        tbl.push_back(mk(0,0,1, 0,3,0, 0,0,8'h00, 1,0,1,1));
        tbl.push_back(mk(0,1,1, 0,3,0, 0,0,8'h00, 1,0,1,1));
        tbl.push_back(mk(0,0,1, 0,3,0, 0,0,8'h00, 0,1,1,1));
        tbl.push_back(mk(0,0,1, 0,3,0, 0,0,8'h00, 0,0,1,1));
        // Scan: start clears sel_err, 7 captures, stop with ready low.
        tbl.push_back(mk(1,0,1, 1,0,0, 0,0,8'h00, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,0,8'hA1, 1,0,1,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,1,8'hB2, 1,0,2,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,2,8'hC3, 1,0,3,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,0,8'hA1, 1,0,4,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,1,8'hB2, 1,0,5,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,2,8'hC3, 1,0,6,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 1,0,8'hA1, 1,0,7,0));
        tbl.push_back(mk(0,1,0, 1,0,0, 1,0,8'hA1, 1,0,7,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 1,0,8'hA1, 1,0,7,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 0,0,8'h00, 0,1,7,0));
        tbl.push_back(mk(0,0,1, 1,0,0, 0,0,8'h00, 0,0,7,0));
        // Burst with zero length finishes with no beats.
        tbl.push_back(mk(1,0,1, 2,0,0, 0,0,8'h00, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 2,0,0, 0,0,8'h00, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 2,0,0, 0,0,8'h00, 0,1,0,0));
        tbl.push_back(mk(0,0,1, 2,0,0, 0,0,8'h00, 0,0,0,0));

        // Asynchronous reset takes effect without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy,      0);
        check("rst_done",  done,      0);
        check("rst_err",   sel_err,   0);
        check("rst_cnt",   beat_cnt,  0);
        check("rst_data",  out_data,  0);
        check("rst_ch",    out_ch,    0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            start     = tbl[i].st;
            stop      = tbl[i].sp;
            out_ready = tbl[i].rdy;
            mode      = tbl[i].md;
            sel_in    = tbl[i].sel;
            burst_len = tbl[i].len;
            step();
            $display("vec %0d: st=%0d sp=%0d rdy=%0d -> v=%0d ch=%0d d=%h busy=%0d done=%0d cnt=%0d err=%0d",
                     i, tbl[i].st, tbl[i].sp, tbl[i].rdy, out_valid, out_ch, out_data,
                     busy, done, beat_cnt, sel_err);
            check($sformatf("v%0d_valid", i), out_valid, tbl[i].v);
            check($sformatf("v%0d_busy", i),  busy,      tbl[i].bsy);
            check($sformatf("v%0d_done", i),  done,      tbl[i].dn);
            check($sformatf("v%0d_cnt", i),   beat_cnt,  tbl[i].cnt);
            check($sformatf("v%0d_err", i),   sel_err,   tbl[i].err);
            if (tbl[i].v) begin
                check($sformatf("v%0d_ch", i),   out_ch,   tbl[i].ch);
                check($sformatf("v%0d_data", i), out_data, tbl[i].d);
            end
        end

        // Start while busy is ignored, then reset mid-run discards the pending beat.
        start = 1'b1; stop = 1'b0; mode = 2'd2; burst_len = 8'd5; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        check("mid_valid", out_valid, 1);
        check("mid_ch",    out_ch,    0);
        check("mid_cnt",   beat_cnt,  1);
        start = 1'b1;
        step();
        $display("busy start: v=%0d ch=%0d cnt=%0d busy=%0d", out_valid, out_ch, beat_cnt, busy);
        check("restart_cnt",  beat_cnt, 2);
        check("restart_ch",   out_ch,   1);
        check("restart_busy", busy,     1);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("mid-run reset: v=%0d busy=%0d cnt=%0d", out_valid, busy, beat_cnt);
        check("mrst_valid", out_valid, 0);
        check("mrst_busy",  busy,      0);
        check("mrst_cnt",   beat_cnt,  0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_busy",  busy,      0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_done",  done,      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Parametrised N-channel, W-bit registered multiplexer with a sequencing engine. It generalises the fixed 3:1 single-bit mux.
- Supports three modes:
  - manual select
  - continuous round-robin scan
  - counted burst scan, which self-terminates after a programmed number of beats
- Output is a valid/ready stream with hold. It feeds capture/logging blocks and stimulus benches in the digital-lab designs.

Parameters:
- N_CH, 3, number of input channels (≥2; need not be a power of 2)
- W, 8, data width per channel
- CNT_W, 8, width of burst length and beat counter
- SEL_W, $clog2(N_CH), channel index width (derived; do not override)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_data  in  N_CH*W  packed channels; channel k = in_data[k*W +: W]
- mode  in  2  0=MANUAL, 1=SCAN, 2=BURST, 3=reserved (treated as SCAN); sampled only on accepted start
- sel_in  in  SEL_W  channel used in MANUAL mode, sampled at each capture
- burst_len  in  CNT_W  beat count for BURST; sampled on accepted start
- start  in  1  single-cycle request to begin a run
- stop  in  1  single-cycle request to end a run
- out_data  out  W  captured sample
- out_ch  out  SEL_W  channel index of out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  downstream accept
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse in DONE
- sel_err  out  1  sticky: MANUAL capture attempted with sel_in ≥ N_CH; cleared on accepted start
- beat_cnt  out  CNT_W  beats captured since last start; saturates at all-ones

Behaviour:
- Reset (async, any state): state=IDLE, out_data=0, out_ch=0, out_valid=0, busy=0, done=0, sel_err=0, beat_cnt=0, internal scan pointer=0.
- States:
  - IDLE:
    - start=1 and stop=0 → RUN; latch mode and burst_len; scan pointer=0; beat_cnt=0; sel_err=0.
    - start with stop in the same cycle → start ignored.
    - stop alone → ignored.
  - RUN:
    - Capture condition: (!out_valid || out_ready).
    - On capture: out_data ← selected channel; out_ch ← index; out_valid ← 1; beat_cnt++.
    - SCAN/BURST: channel = scan pointer, which advances modulo N_CH (N_CH-1 wraps to 0).
    - MANUAL: channel = sel_in. If sel_in ≥ N_CH, no capture, sel_err ← 1, and out_valid follows the normal handshake.
    - out_valid & out_ready with no capture → out_valid ← 0.
    - stop=1 → DRAIN. A capture in that same cycle still occurs.
    - BURST: the capture that makes beat_cnt == latched burst_len → DRAIN.
    - BURST with burst_len=0 → DRAIN on the first RUN cycle with no capture.
  - DRAIN:
    - No captures.
    - Leave when out_valid=0, or when out_valid & out_ready (out_valid ← 0 that edge) → DONE.
  - DONE:
    - done=1 for exactly one cycle, then IDLE.
- Handshake:
  - out_data and out_ch are stable while out_valid & !out_ready.
  - Full throughput: one beat per cycle when out_ready is held high.
  - out_valid never drops without a transfer, except on reset.
- Ignored inputs:
  - start while busy or in DONE is ignored.
  - mode and burst_len changes mid-run are ignored.
- Latency:
  - Start sampled at edge 0 → RUN after edge 0.
  - First capture at edge 1, so out_valid is high after edge 1.
  - done is high in the cycle after the final transfer edge.
- Reset mid-run: all outputs return to reset values immediately; the pending beat is discarded.

Decomposition:
- Package mux_scan_pkg holds:
  - state_t enum: IDLE, RUN, DRAIN, DONE
  - mode constants: MODE_MANUAL=2'd0, MODE_SCAN=2'd1, MODE_BURST=2'd2
- One sub-module: mux_n1, a combinational N_CH:1, W-bit selector with an in_range flag. It is reusable elsewhere.
- The FSM, counters and output register stay in mux_scan_seq.

Test Plan:
- Setup: N_CH=3, W=8, in_data = {8'hC3, 8'hB2, 8'hA1}.
- Reset mid-run: assert rst during RUN with out_valid=1 → same cycle out_valid=0, busy=0, beat_cnt=0; state IDLE after release.
- BURST, burst_len=5, out_ready=1: start → out_ch sequence 0,1,2,0,1 with data A1,B2,C3,A1,B2 on consecutive cycles; beat_cnt=5; done pulse once; busy then low.
- BURST, burst_len=4, out_ready toggling 1,0,0,1,…: held beats are unchanged while ready=0; exactly 4 transfers; no beat lost or duplicated.
- MANUAL: sel_in=2 → out_data=C3; then sel_in=3 → no new beat and sel_err=1; stop → drains, done pulse; next start clears sel_err.
- SCAN with stop after 7 captures, out_ready=0 at stop: DRAIN holds the beat; ready=1 → transfer, then done. Also check burst_len=0 → done with zero beats, and start+stop in the same cycle → stays IDLE.
